expr_stream_gen: RTL and testbench
==================================

Name: expr_stream_gen

Overview:
- Transmit-side companion to the expression-string recogniser.
- Host loads a short sequence of decimal digits and operators into an internal token buffer.
- On start, the block emits a grammatically valid ASCII expression, one byte per valid/ready handshake: digit, then (op digit)*.
- Output feeds the recogniser's 8-bit `in` port, or a UART/test harness, so the checker receives only well-formed frames.

Parameters:
- DEPTH, 8, number of token buffer entries (max operands per frame); must equal 2**AW.
- AW, 3, index/pointer width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- clr  in  1  asynchronous, active-high reset.
- wr_en  in  1  push one token into the buffer.
- wr_digit  in  4  operand value, legal 0..9.
- wr_op  in  1  operator preceding this operand: 0 = '+', 1 = '*'. Ignored for the first token.
- start  in  1  begin emitting the buffered frame.
- out_ready  in  1  downstream accepts out_char this cycle.
- out_valid  out  1  out_char is valid.
- out_char  out  8  ASCII byte.
- busy  out  1  frame emission in progress.
- done  out  1  one-cycle pulse after the last byte is accepted.
- wr_err  out  1  one-cycle pulse when a write is dropped.
- count  out  AW+1  tokens currently buffered.

Behaviour:
- Reset (clr=1, asynchronous):
  - state=IDLE; count=0; idx=0.
  - out_valid=0, out_char=8'h00, busy=0, done=0, wr_err=0.
  - Buffer contents are don't-care.
  - Reset mid-frame aborts immediately; no further bytes; no done pulse.
- Write acceptance: a write is accepted only when wr_en=1, state=IDLE, start=0, count<DEPTH and wr_digit<=9.
  - Accepted: stores {wr_op, wr_digit} at entry[count]; count increments next cycle.
  - Dropped: if wr_en=1 but any condition fails (busy, full, digit>9, simultaneous start), the write is dropped and wr_err=1 on the next cycle for exactly one cycle.
- Start handling:
  - In IDLE with count>=1: next state DIG, idx=0, busy=1.
  - In IDLE with count=0: ignored.
  - Outside IDLE: ignored, no error.
- FSM states: IDLE, DIG, OP, TERM (TERM_EN only), FIN.
  - DIG: out_valid=1, out_char = 8'h30 + entry[idx].digit.
    - On out_valid&out_ready: if idx==count-1, go to TERM (TERM_EN) else FIN.
    - Otherwise go to OP.
  - OP: out_valid=1, out_char = entry[idx+1].op ? 8'h2A ('*') : 8'h2B ('+').
    - On handshake: idx<=idx+1, go to DIG.
  - TERM: out_valid=1, out_char = 8'h3D ('='). On handshake go to FIN.
  - FIN: out_valid=0, done=1 for this one cycle, count<=0, busy=0, go to IDLE.
  - IDLE: out_valid=0, out_char=8'h00, busy=0.
- Outputs are Moore, decoded from registered state/idx.
  - out_char must stay stable while out_valid=1 and out_ready=0.
  - Backpressure of any length is legal.
- Throughput: one byte per cycle with out_ready held high.
  - Frame of N operands = 2N-1 bytes (2N with TERM_EN).
  - done asserts the cycle after the last handshake.
- idx never exceeds count-1. Entries at or above count are never read.
- A full buffer (count=DEPTH) emits 2*DEPTH-1 bytes correctly; count returns to 0 after FIN.

Optional Feature:
- Macro: EXPR_TERM_EN.
- Defined: TERM state present; '=' (8'h3D) is appended after the last digit as an end-of-frame marker.
- Undefined: TERM state not compiled; the last digit handshake goes directly to FIN.

Test Plan:
- Write (d=3), (d=5,op=1), (d=7,op=0); start; out_ready=1 -> bytes "3","*","5","+","7" on consecutive cycles; done pulse one cycle after "7"; count=0.
- Same frame with out_ready toggling 1,0,0,1 per cycle -> out_char held stable during stalls; identical byte sequence; no duplicate or lost bytes.
- Write wr_digit=4'd12 -> wr_err pulse, count unchanged. Fill 8 entries, then a 9th write -> wr_err pulse, count=8. Emit -> 15 bytes.
- start with count=0 -> out_valid stays 0, no done. wr_en during busy -> wr_err, count unchanged.
- Assert clr after the 2nd byte of a 5-byte frame -> out_valid=0 immediately, busy=0, count=0, no done.
- EXPR_TERM_EN defined, single token d=9 -> bytes "9","=" then done. Undefined -> "9" only, then done.

Source files
------------

// File: rtl/expr_stream_gen.sv
// -----------------------------------------------------------------------------
// expr_stream_gen
//
// Transmit-side companion to the expression-string recogniser. The host loads
// up to DEPTH tokens (operand digit plus the operator that precedes it) into a
// small buffer. On start the block emits a well-formed ASCII expression,
// digit (op digit)*, one byte per out_valid/out_ready handshake.
//
// Optional build macro:
//   EXPR_TERM_EN  - when defined, an '=' byte is appended after the last digit
//                   as an end-of-frame marker (TERM state). When undefined the
//                   last digit handshake goes straight to FIN.
//
// Parameters:
//   DEPTH  token buffer entries; must equal 2**AW
//   AW     index / pointer width
//
// Ports:
//   clk        clock, all state changes on posedge
//   clr        asynchronous, active-high reset
//   wr_en      push one token {wr_op, wr_digit}
//   wr_digit   operand value, legal 0..9
//   wr_op      operator preceding this operand (0 '+', 1 '*'), unused on token 0
//   start      begin emitting the buffered frame
//   out_ready  downstream accepts out_char this cycle
//   out_valid  out_char is valid
//   out_char   ASCII byte
//   busy       frame emission in progress
//   done       one-cycle pulse after the last byte is accepted
//   wr_err     one-cycle pulse when a write is dropped
//   count      tokens currently buffered
// -----------------------------------------------------------------------------
module expr_stream_gen #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [3:0]    wr_digit,
  input  logic          wr_op,
  input  logic          start,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [7:0]    out_char,
  output logic          busy,
  output logic          done,
  output logic          wr_err,
  output logic [AW:0]   count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DIG  = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
`ifdef EXPR_TERM_EN
  localparam logic [2:0] S_TERM = 3'd3;
`endif
  localparam logic [2:0] S_FIN  = 3'd4;

  localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE_C = (AW+1)'(1'b1);
  localparam logic [AW-1:0] IDX_ONE_C = AW'(1'b1);

  // ASCII code of a decimal digit
  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  // ASCII code of the operator bit
  function automatic logic [7:0] op_char(input logic op);
    return op ? 8'h2A : 8'h2B;
  endfunction

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   count_q, count_d;
  logic          wr_err_q, wr_err_d;
  logic [4:0]    entry_q [DEPTH];

  logic          wr_accept_s;
  logic          hs_s;
  logic          last_s;
  logic [AW-1:0] nxt_idx_s;

  // Write qualification, handshake and end-of-frame decode
  always_comb begin
    wr_accept_s = wr_en && (state_q == S_IDLE) && !start &&
                  (count_q < DEPTH_C) && (wr_digit <= 4'd9);
    hs_s        = out_valid && out_ready;
    // idx is only compared while emitting, where count_q >= 1
    last_s      = ({1'b0, idx_q} == (count_q - CNT_ONE_C));
    nxt_idx_s   = idx_q + IDX_ONE_C;
  end

  // Next-state logic for FSM, index, fill count and write-error pulse
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    count_d  = count_q;
    wr_err_d = wr_en && !wr_accept_s;
    case (state_q)
      S_IDLE: begin
        if (wr_accept_s) begin
          count_d = count_q + CNT_ONE_C;
        end else if (start && (count_q != {(AW+1){1'b0}})) begin
          state_d = S_DIG;
          idx_d   = {AW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DIG: begin
        if (hs_s) begin
          if (last_s) begin
`ifdef EXPR_TERM_EN
            state_d = S_TERM;
`else
            state_d = S_FIN;
`endif
          end else begin
            state_d = S_OP;
          end
        end else begin
          state_d = S_DIG;
        end
      end
      S_OP: begin
        if (hs_s) begin
          idx_d   = nxt_idx_s;
          state_d = S_DIG;
        end else begin
          state_d = S_OP;
        end
      end
`ifdef EXPR_TERM_EN
      S_TERM: begin
        if (hs_s) begin
          state_d = S_FIN;
        end else begin
          state_d = S_TERM;
        end
      end
`endif
      S_FIN: begin
        count_d = {(AW+1){1'b0}};
        idx_d   = {AW{1'b0}};
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = {AW{1'b0}};
        count_d = {(AW+1){1'b0}};
      end
    endcase
  end

  // Control state registers, cleared asynchronously by clr
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= S_IDLE;
      idx_q    <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      count_q  <= count_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Token buffer; contents are don't-care after reset so it carries none
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      entry_q[count_q[AW-1:0]] <= {wr_op, wr_digit};
    end
  end

  // Moore output decode; everything depends only on registered state
  always_comb begin
    out_valid = 1'b0;
    out_char  = 8'h00;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_DIG: begin
        out_valid = 1'b1;
        out_char  = ascii_digit(entry_q[idx_q][3:0]);
        busy      = 1'b1;
      end
      S_OP: begin
        // operator belongs to the operand that follows it
        out_valid = 1'b1;
        out_char  = op_char(entry_q[nxt_idx_s][4]);
        busy      = 1'b1;
      end
`ifdef EXPR_TERM_EN
      S_TERM: begin
        out_valid = 1'b1;
        out_char  = 8'h3D;
        busy      = 1'b1;
      end
`endif
      S_FIN: begin
        done = 1'b1;
      end
      default: begin
        out_valid = 1'b0;
        out_char  = 8'h00;
      end
    endcase
  end

  assign wr_err = wr_err_q;
  assign count  = count_q;

endmodule

// File: tb/tb_expr_stream_gen.sv
module tb_expr_stream_gen;

  logic       clk = 1'b0;
  logic       clr;
  logic       wr_en;
  logic [3:0] wr_digit;
  logic       wr_op;
  logic       start;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_char;
  logic       busy;
  logic       done;
  logic       wr_err;
  logic [3:0] count;

`ifdef EXPR_TERM_EN
  localparam int TERM_C = 1;
`else
  localparam int TERM_C = 0;
`endif

  expr_stream_gen #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_digit(wr_digit), .wr_op(wr_op),
    .start(start), .out_ready(out_ready), .out_valid(out_valid),
    .out_char(out_char), .busy(busy), .done(done), .wr_err(wr_err),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // expected events: bit8=0 -> byte in [7:0]; bit8=1 -> done pulse
  logic [8:0] sb[$];
  // tokens the bench believes are buffered: {op, digit}
  logic [4:0] model[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake / done pulse
  logic       prev_stall = 1'b0;
  logic [7:0] prev_char  = 8'h00;
  always @(negedge clk) begin
    logic [8:0] e;
    if (clr) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_char", out_char, prev_char);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_byte_q", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("byte", {1'b0, out_char}, e);
        end
      end
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done_q", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("done_order", {done, 8'h00}, e);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_char  = out_char;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] d, input logic o, input bit exp_ok);
    wr_en = 1'b1; wr_digit = d; wr_op = o;
    step();
    wr_en = 1'b0;
    if (exp_ok) model.push_back({o, d});
    chk("wr_err_pulse", wr_err, exp_ok ? 0 : 1);
    chk("count_after_wr", count, model.size());
    if (!exp_ok) begin
      step();
      chk("wr_err_clear", wr_err, 0);
    end
  endtask

  task automatic push_expect();
    sb.push_back({1'b0, 8'h30 + {4'h0, model[0][3:0]}});
    for (int i = 1; i < model.size(); i++) begin
      sb.push_back({1'b0, model[i][4] ? 8'h2A : 8'h2B});
      sb.push_back({1'b0, 8'h30 + {4'h0, model[i][3:0]}});
    end
    if (TERM_C != 0) sb.push_back({1'b0, 8'h3D});
    sb.push_back(9'h100);
  endtask

  // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating
  task automatic run_frame(input int mode, input bit chk_cyc, input bit busy_wr);
    int  cyc;
    bit  seen;
    int  n;
    n = model.size();
    push_expect();
    out_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    if (busy_wr) begin
      wr_en = 1'b1; wr_digit = 4'd1; wr_op = 1'b0;
      step();
      wr_en = 1'b0;
      chk("busy_wr_err", wr_err, 1);
      chk("busy_wr_count", count, n);
    end
    cyc = 0; seen = 0;
    for (int i = 0; i < 200; i++) begin
      out_ready = (mode == 0) ? 1'b1 : ((i % 4 == 0) || (i % 4 == 3));
      step();
      cyc++;
      if (done) begin seen = 1; break; end
    end
    chk("done_seen", seen, 1);
    if (chk_cyc) chk("frame_cycles", cyc, 2 * n - 1 + TERM_C);
    out_ready = 1'b0;
    step();
    chk("done_one_cycle", done, 0);
    chk("count_cleared", count, 0);
    chk("busy_cleared", busy, 0);
    chk("sb_empty", sb.size(), 0);
    model.delete();
  endtask

  initial begin
    clr = 1'b1; wr_en = 1'b0; wr_digit = 4'd0; wr_op = 1'b0;
    start = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_count", count, 0);
    step();
    clr = 1'b0;
    step();

    // 3*5+7 at full rate
    wr(4'd3, 1'b0, 1); wr(4'd5, 1'b1, 1); wr(4'd7, 1'b0, 1);
    run_frame(0, 1, 0);

    // same frame under backpressure
    wr(4'd3, 1'b0, 1); wr(4'd5, 1'b1, 1); wr(4'd7, 1'b0, 1);
    run_frame(1, 0, 0);

    // illegal digit dropped
    wr(4'd12, 1'b0, 0);

    // fill buffer, overflow write, then emit 15 bytes
    for (int i = 0; i < 8; i++) wr(4'(i + 2 > 9 ? i - 5 : i + 2), 1'(i % 2), 1);
    wr(4'd4, 1'b1, 0);
    chk("full_count", count, 8);
    run_frame(0, 1, 0);

    // start with empty buffer is ignored; simultaneous wr+start is dropped
    start = 1'b1; wr_en = 1'b1; wr_digit = 4'd6; wr_op = 1'b0;
    step();
    start = 1'b0; wr_en = 1'b0;
    chk("wr_start_err", wr_err, 1);
    chk("wr_start_count", count, 0);
    for (int i = 0; i < 4; i++) begin
      chk("empty_start_valid", out_valid, 0);
      chk("empty_start_done", done, 0);
      step();
    end

    // write during emission dropped
    wr(4'd1, 1'b0, 1); wr(4'd2, 1'b0, 1);
    run_frame(0, 0, 1);

    // reset after second byte of 1+2*3
    wr(4'd1, 1'b0, 1); wr(4'd2, 1'b0, 1); wr(4'd3, 1'b1, 1);
    sb.push_back({1'b0, 8'h31});
    sb.push_back({1'b0, 8'h2B});
    start = 1'b1;
    step();
    start = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    clr = 1'b1;
    #1;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_count", count, 0);
    chk("clr_done", done, 0);
    chk("clr_sb_empty", sb.size(), 0);
    model.delete();
    step();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_clr_done", done, 0);
      chk("post_clr_valid", out_valid, 0);
    end
    out_ready = 1'b0;

    // single token frame
    wr(4'd9, 1'b1, 1);
    run_frame(0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
